// File: rtl/bmi_comparator.sv
// bmi_comparator: classifies an 8-bit unsigned BMI category into one of
// underweight / normal / overweight, registers a one-hot class per accepted
// sample and keeps saturating per-class sample counters.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          category is valid this cycle
//   category[7:0]     unsigned category value
//   clear             synchronous clear of the three counters (wins over counting)
//   out_valid         one-cycle pulse per accepted sample
//   underweight       last accepted sample <= UNDER_MAX
//   normal            last accepted sample in (UNDER_MAX, NORMAL_MAX]
//   overweight        last accepted sample > NORMAL_MAX
//   zero_flag         last accepted sample was 0
//   under_cnt, normal_cnt, over_cnt  saturating per-class counts
module bmi_comparator #(
   parameter int unsigned UNDER_MAX  = 18,
   parameter int unsigned NORMAL_MAX = 24,
   parameter int unsigned COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [7:0]         category,
   input  logic               clear,
   output logic               out_valid,
   output logic               underweight,
   output logic               normal,
   output logic               overweight,
   output logic               zero_flag,
   output logic [COUNT_W-1:0] under_cnt,
   output logic [COUNT_W-1:0] normal_cnt,
   output logic [COUNT_W-1:0] over_cnt
);

   localparam logic [7:0]         UNDER_LIM  = 8'(UNDER_MAX);
   localparam logic [7:0]         NORMAL_LIM = 8'(NORMAL_MAX);
   localparam logic [COUNT_W-1:0] CNT_MAX    = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);

   logic is_under_c;
   logic is_normal_c;
   logic is_over_c;
   logic is_zero_c;

   // Unsigned class decode of the incoming sample; exactly one class is set.
   always_comb begin
      is_under_c  = (category <= UNDER_LIM);
      is_normal_c = !is_under_c && (category <= NORMAL_LIM);
      is_over_c   = !is_under_c && !is_normal_c;
      is_zero_c   = (category == 8'd0);
   end

   // Registered class outputs; they hold while no sample is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         underweight <= 1'b0;
         normal      <= 1'b0;
         overweight  <= 1'b0;
         zero_flag   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            underweight <= is_under_c;
            normal      <= is_normal_c;
            overweight  <= is_over_c;
            zero_flag   <= is_zero_c;
         end
      end
   end

   // Saturating per-class counters; clear takes priority over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         under_cnt  <= '0;
         normal_cnt <= '0;
         over_cnt   <= '0;
      end else if (clear) begin
         under_cnt  <= '0;
         normal_cnt <= '0;
         over_cnt   <= '0;
      end else if (in_valid) begin
         if (is_under_c && (under_cnt != CNT_MAX))
            under_cnt <= under_cnt + CNT_ONE;
         if (is_normal_c && (normal_cnt != CNT_MAX))
            normal_cnt <= normal_cnt + CNT_ONE;
         if (is_over_c && (over_cnt != CNT_MAX))
            over_cnt <= over_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_bmi_comparator.sv
// Testbench for bmi_comparator (COUNT_W = 4 so counter saturation is reachable).
module tb_bmi_comparator;

   localparam int unsigned CW   = 4;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    category = 8'd0;
   logic          clear = 1'b0;
   logic          out_valid, underweight, normal, overweight, zero_flag;
   logic [CW-1:0] under_cnt, normal_cnt, over_cnt;

   bmi_comparator #(.UNDER_MAX(18), .NORMAL_MAX(24), .COUNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .category   (category),
      .clear      (clear),
      .out_valid  (out_valid),
      .underweight(underweight),
      .normal     (normal),
      .overweight (overweight),
      .zero_flag  (zero_flag),
      .under_cnt  (under_cnt),
      .normal_cnt (normal_cnt),
      .over_cnt   (over_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: class 0 = none yet, 1 = under, 2 = normal, 3 = over.
   int m_cls  = 0;
   bit m_ov   = 0;
   bit m_zero = 0;
   int m_cnt [1:3];

   logic [16:0] dut_vec;
   assign dut_vec = {out_valid, underweight, normal, overweight, zero_flag,
                     under_cnt, normal_cnt, over_cnt};

   function automatic logic [16:0] exp_vec();
      return {m_ov, m_cls == 1, m_cls == 2, m_cls == 3, m_zero,
              4'(m_cnt[1]), 4'(m_cnt[2]), 4'(m_cnt[3])};
   endfunction

   task automatic model_reset();
      m_cls = 0; m_ov = 0; m_zero = 0;
      for (int k = 1; k <= 3; k++) m_cnt[k] = 0;
   endtask

   task automatic model_step(input bit v, input int c, input bit clr);
      int cls;
      cls = (c <= 18) ? 1 : (c <= 24) ? 2 : 3;
      m_ov = v;
      if (v) begin
         m_cls  = cls;
         m_zero = (c == 0);
      end
      if (clr) begin
         for (int k = 1; k <= 3; k++) m_cnt[k] = 0;
      end else if (v && m_cnt[cls] < CMAX) begin
         m_cnt[cls] = m_cnt[cls] + 1;
      end
   endtask

   // Apply one cycle of stimulus and advance the model; sampling is at edge + 1.
   task automatic drive(input bit v, input bit [7:0] c, input bit clr);
      in_valid = v; category = c; clear = clr;
      @(posedge clk);
      #1;
      model_step(v, int'(c), clr);
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++;
         $display("FAIL reset got=%h exp=%h", dut_vec, exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bit [7:0] vals [3];
      vals[0] = 8'd12; vals[1] = 8'd140; vals[2] = 8'd23;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, vals[i], 1'b0);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL basic cat=%0d got=%h exp=%h", vals[i], dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_boundary();
      bit [7:0] vals [7];
      vals[0] = 8'd18; vals[1] = 8'd19; vals[2] = 8'd24; vals[3] = 8'd25;
      vals[4] = 8'd0;  vals[5] = 8'd255; vals[6] = 8'd1;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, vals[i], 1'b0);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL boundary cat=%0d got=%h exp=%h", vals[i], dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_hold();
      drive(1'b1, 8'd30, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) drive(1'b0, 8'($urandom), 1'b0);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL hold cycle=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_saturation();
      drive(1'b0, 8'd0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(19 + $urandom_range(0, 5)), 1'b0);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL saturate n=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
      drive(1'b1, 8'd20, 1'b1);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++;
         $display("FAIL clear_wins got=%h exp=%h", dut_vec, exp_vec());
      end
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit [7:0] edges [8];
      bit [7:0] c;
      edges[0] = 8'd0;  edges[1] = 8'd17; edges[2] = 8'd18; edges[3] = 8'd19;
      edges[4] = 8'd24; edges[5] = 8'd25; edges[6] = 8'd127; edges[7] = 8'd128;
      for (int i = 0; i < 300; i++) begin
         c = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 7)] : 8'($urandom);
         drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 15) == 0);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL random i=%0d cat=%0d got=%h exp=%h", i, c, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'd200, 1'b0);
      in_valid = 1'b1; category = 8'd10; clear = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++;
         $display("FAIL async_reset got=%h exp=%h", dut_vec, exp_vec());
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_edge got=%h exp=%h", dut_vec, exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'd21, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++;
         $display("FAIL post_reset got=%h exp=%h", dut_vec, exp_vec());
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_hold();
      test_saturation();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bmi_comparator.md
# bmi_comparator

Synchronous classifier that maps an 8-bit unsigned body-mass category value onto exactly one of three weight classes: underweight, normal or overweight. It sits downstream of the BMI computation stage. It registers a one-hot class result per accepted sample and keeps saturating per-class sample counts for status reporting.

## Interface

Parameters:
- `UNDER_MAX`, default 18: largest category value classed underweight.
- `NORMAL_MAX`, default 24: largest category value classed normal; must satisfy `NORMAL_MAX > UNDER_MAX`.
- `COUNT_W`, default 16: width of each per-class counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  `category` is valid this cycle.
- `category`  input  8  unsigned category value (integer BMI).
- `clear`  input  1  synchronous clear of the three counters.
- `out_valid`  output  1  class outputs updated this cycle (one-cycle pulse per accepted sample).
- `underweight`  output  1  last accepted sample had `category <= UNDER_MAX`.
- `normal`  output  1  last accepted sample had `UNDER_MAX < category <= NORMAL_MAX`.
- `overweight`  output  1  last accepted sample had `category > NORMAL_MAX`.
- `zero_flag`  output  1  last accepted sample had `category == 0`.
- `under_cnt`, `normal_cnt`, `over_cnt`  output  `COUNT_W` each  saturating per-class sample counts.

## Operation

- Classification: unsigned compare, full 8-bit range 0–255; no signed interpretation (140 is overweight).
  - `category` 0..`UNDER_MAX` -> underweight.
  - `UNDER_MAX`+1..`NORMAL_MAX` -> normal.
  - `NORMAL_MAX`+1..255 -> overweight.
- Exactly one of `underweight`, `normal`, `overweight` is high after the first accepted sample. All three are low only from reset until the first accepted sample.
- `category == 0` is classed underweight and additionally sets `zero_flag`. Any nonzero accepted sample clears `zero_flag`.
- When `in_valid` is low:
  - class outputs and `zero_flag` hold their previous values.
  - `out_valid` is 0.
  - counters hold.
- Counters:
  - on each accepted sample, the counter of the selected class increments by 1.
  - counters saturate at all-ones, with no wrap.
- `clear`:
  - zeroes all three counters.
  - does not affect the class outputs, `zero_flag` or `out_valid`.
  - if `clear` and `in_valid` are both high in the same cycle, `clear` wins: counters go to 0 and the sample is not counted, but it is still classified and `out_valid` pulses.

## Timing

- Latency 1 cycle: a sample accepted at edge N appears on the class outputs, `zero_flag`, `out_valid` and the counters after edge N.
- Full throughput: one sample per cycle, with no backpressure.
- Reset (`rst_n` = 0):
  - immediate and asynchronous.
  - `out_valid`, `underweight`, `normal`, `overweight` and `zero_flag` = 0; all counters = 0.
- Release of `rst_n` is taken synchronously. The first sample can be accepted on the first rising edge with `rst_n` = 1.
- Reset asserted mid-stream discards any in-flight sample. No output pulses on the edge coincident with reset.

## Test plan

- Reset then `category` = 12 (0x0C) with `in_valid` -> next cycle: `underweight` = 1, `normal` = `overweight` = 0, `out_valid` = 1, `under_cnt` = 1.
- `category` = 140 (0x8C) -> `overweight` = 1 only (unsigned compare); `over_cnt` increments. `category` = 23 (0x17) -> `normal` = 1 only.
- Boundary sweep with defaults:
  - 18 -> underweight.
  - 19 -> normal.
  - 24 -> normal.
  - 25 -> overweight.
  - 0 -> underweight with `zero_flag` = 1.
  - 255 -> overweight.
- `in_valid` low for 5 cycles after a sample -> outputs hold, `out_valid` = 0, counters unchanged.
- Counter saturation with `COUNT_W` = 4: 20 consecutive normal samples -> `normal_cnt` = 15. Then `clear` together with a normal sample -> `normal_cnt` = 0 and `normal` = 1.
- Assert `rst_n` low asynchronously between edges during a stream -> all outputs and counters 0 immediately. After release, the first sample classifies correctly.
